// File: rtl/acs_pkg.sv
// Shared definitions for the ALU control stage: opcodes, ALU op encodings,
// instruction field positions and the stage FSM state type.
package acs_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RD_HI  = 25;
  localparam int unsigned RD_LO  = 21;
  localparam int unsigned RS_HI  = 20;
  localparam int unsigned RS_LO  = 16;
  localparam int unsigned RT_HI  = 15;
  localparam int unsigned RT_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam logic [5:0] OPC_REG_MAX = 6'h07;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_SLTI    = 6'h09;
  localparam logic [5:0] OPC_NOP     = 6'h3F;

  typedef enum logic [2:0] {
    ALU_MOV  = 3'b000,
    ALU_NOT  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_NAND = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } acs_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode decoder: ALU op, immediate select, register write
// enable and illegal-opcode flag.
module alu_ctrl_dec
  import acs_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [2:0]         aluop,
  output logic               use_imm,
  output logic               regwrite,
  output logic               illegal
);

  logic [5:0] opcode;
  logic       unused_fields;

  assign opcode        = instr[OPC_HI:OPC_LO];
  assign unused_fields = ^instr[RD_HI:IMM_LO];

  always_comb begin
    aluop    = ALU_MOV;
    use_imm  = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    if (opcode <= OPC_REG_MAX) begin
      // Register-register ops carry the ALU op directly in the low opcode bits
      aluop    = opcode[2:0];
      regwrite = 1'b1;
    end else begin
      case (opcode)
        OPC_ADDI: begin
          aluop    = ALU_ADD;
          use_imm  = 1'b1;
          regwrite = 1'b1;
        end
        OPC_SLTI: begin
          aluop    = ALU_SLT;
          use_imm  = 1'b1;
          regwrite = 1'b1;
        end
        OPC_NOP: begin
          aluop    = ALU_MOV;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode pipeline stage with valid/ready handshake, saturating illegal-opcode
// counter and optional RAW hazard stall (build macro ACS_HAZARD_STALL_EN).
module alu_ctrl_stage
  import acs_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic               ACS_CLK,
  input  logic               ACS_RST,
  input  logic               ACS_FLUSH,
  input  logic               ACS_IN_VALID,
  output logic               ACS_IN_READY,
  input  logic [INSTR_W-1:0] ACS_INSTR,
  output logic               ACS_OUT_VALID,
  input  logic               ACS_OUT_READY,
  output logic [2:0]         ACS_ALUOP,
  output logic [4:0]         ACS_RD,
  output logic [4:0]         ACS_RS,
  output logic [4:0]         ACS_RT,
  output logic [N-1:0]       ACS_IMM,
  output logic               ACS_USE_IMM,
  output logic               ACS_REGWRITE,
  output logic [7:0]         ACS_ILLEGAL_CNT
);

  logic [2:0]   dec_aluop;
  logic         dec_use_imm;
  logic         dec_regwrite;
  logic         dec_illegal;
  logic [4:0]   in_rd;
  logic [4:0]   in_rs;
  logic [4:0]   in_rt;
  logic [N-1:0] imm_ext;
  logic         hazard;
  logic         accept;
  acs_state_e   state;

  alu_ctrl_dec u_dec (
    .instr    (ACS_INSTR),
    .aluop    (dec_aluop),
    .use_imm  (dec_use_imm),
    .regwrite (dec_regwrite),
    .illegal  (dec_illegal)
  );

  assign in_rd = ACS_INSTR[RD_HI:RD_LO];
  assign in_rs = ACS_INSTR[RS_HI:RS_LO];
  assign in_rt = ACS_INSTR[RT_HI:RT_LO];

  always_comb begin
    imm_ext               = {N{ACS_INSTR[IMM_HI]}};
    imm_ext[IMM_HI:IMM_LO] = ACS_INSTR[IMM_HI:IMM_LO];
  end

`ifdef ACS_HAZARD_STALL_EN
  // Destination of the instruction accepted on the previous cycle, if it writes
  logic       trk_valid;
  logic [4:0] trk_rd;

  always_comb begin
    hazard = ACS_IN_VALID && trk_valid && (trk_rd != '0) &&
             ((trk_rd == in_rs) || (!dec_use_imm && (trk_rd == in_rt)));
  end

  always_ff @(posedge ACS_CLK or posedge ACS_RST) begin
    if (ACS_RST) begin
      trk_valid <= 1'b0;
      trk_rd    <= '0;
    end else if (ACS_FLUSH) begin
      trk_valid <= 1'b0;
    end else begin
      trk_valid <= accept && !dec_illegal && dec_regwrite;
      trk_rd    <= in_rd;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign ACS_IN_READY = (!ACS_OUT_VALID || ACS_OUT_READY) && !ACS_FLUSH &&
                        !hazard && (state == ST_RUN);
  assign accept       = ACS_IN_VALID && ACS_IN_READY;

  always_ff @(posedge ACS_CLK or posedge ACS_RST) begin
    if (ACS_RST) begin
      state           <= ST_RUN;
      ACS_OUT_VALID   <= 1'b0;
      ACS_ALUOP       <= ALU_MOV;
      ACS_RD          <= '0;
      ACS_RS          <= '0;
      ACS_RT          <= '0;
      ACS_IMM         <= '0;
      ACS_USE_IMM     <= 1'b0;
      ACS_REGWRITE    <= 1'b0;
      ACS_ILLEGAL_CNT <= '0;
    end else if (ACS_FLUSH) begin
      state         <= ST_RUN;
      ACS_OUT_VALID <= 1'b0;
    end else begin
      case (state)
        ST_RUN:   if (hazard) state <= ST_STALL;
        ST_STALL: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
      if (accept) begin
        // An accepted illegal opcode still retires any held bundle, since
        // acceptance implies downstream took it or it was empty
        if (dec_illegal) begin
          ACS_OUT_VALID <= 1'b0;
          if (ACS_ILLEGAL_CNT != '1) ACS_ILLEGAL_CNT <= ACS_ILLEGAL_CNT + 8'd1;
        end else begin
          ACS_OUT_VALID <= 1'b1;
          ACS_ALUOP     <= dec_aluop;
          ACS_RD        <= in_rd;
          ACS_RS        <= in_rs;
          ACS_RT        <= in_rt;
          ACS_IMM       <= imm_ext;
          ACS_USE_IMM   <= dec_use_imm;
          ACS_REGWRITE  <= dec_regwrite;
        end
      end else if (ACS_OUT_READY) begin
        ACS_OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed scenarios followed by random
// traffic, scored against a queue-based reference of the decode rules.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  aluop;
  logic [4:0]  rd, rs, rt;
  logic [31:0] imm;
  logic        use_imm, regwrite;
  logic [7:0]  illegal_cnt;

  alu_ctrl_stage #(.N(32)) dut (
    .ACS_CLK         (clk),
    .ACS_RST         (rst),
    .ACS_FLUSH       (flush),
    .ACS_IN_VALID    (in_valid),
    .ACS_IN_READY    (in_ready),
    .ACS_INSTR       (instr),
    .ACS_OUT_VALID   (out_valid),
    .ACS_OUT_READY   (out_ready),
    .ACS_ALUOP       (aluop),
    .ACS_RD          (rd),
    .ACS_RS          (rs),
    .ACS_RT          (rt),
    .ACS_IMM         (imm),
    .ACS_USE_IMM     (use_imm),
    .ACS_REGWRITE    (regwrite),
    .ACS_ILLEGAL_CNT (illegal_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [51:0] q[$];
  int unsigned mcnt = 0;
  bit          hz = 1'b0;
  bit          stall_pend = 1'b0;
  bit          last_ok = 1'b0;
  logic [4:0]  last_rd = '0;
  bit          dut_rdy_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bundle = {aluop, rd, rs, rt, imm, use_imm, regwrite}
  function automatic logic [51:0] ref_bundle(input logic [31:0] ins, output bit legal);
    logic [5:0]  op;
    logic [2:0]  a;
    bit          ui, rw;
    logic [31:0] im;
    op = ins[31:26];
    legal = 1'b1;
    a = 3'd0; ui = 1'b0; rw = 1'b0;
    if (op < 6'd8) begin a = op[2:0]; rw = 1'b1; end
    else if (op == 6'd8) begin a = 3'd3; ui = 1'b1; rw = 1'b1; end
    else if (op == 6'd9) begin a = 3'd7; ui = 1'b1; rw = 1'b1; end
    else if (op != 6'd63) legal = 1'b0;
    im = {{16{ins[15]}}, ins[15:0]};
    return {a, ins[25:21], ins[20:16], ins[15:11], im, ui, rw};
  endfunction

  function automatic logic [51:0] dut_bundle();
    return {aluop, rd, rs, rt, imm, use_imm, regwrite};
  endfunction

  // One clock cycle: drive, check, advance the reference, then take the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    bit          exp_rdy, legal, acc;
    logic [51:0] b;
    @(negedge clk);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    #1;
    b = ref_bundle(ins, legal);
`ifdef ACS_HAZARD_STALL_EN
    // Producer from last cycle; immediate-form consumers read RS only
    hz = v && last_ok && (last_rd != 5'd0) &&
         ((last_rd == ins[20:16]) || (!b[1] && (last_rd == ins[15:11])));
`else
    hz = 1'b0;
`endif
    exp_rdy = ((q.size() == 0) || ordy) && !fl && !hz && !stall_pend;
    dut_rdy_seen = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) chk("bundle", {12'd0, dut_bundle()}, {12'd0, q[0]});
    chk("illegal_cnt", {56'd0, illegal_cnt}, 64'(mcnt));
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (fl) q.delete();
    acc = v && exp_rdy;
    if (acc) begin
      if (legal) q.push_back(b);
      else if (mcnt < 255) mcnt++;
    end
    stall_pend = !fl && !stall_pend && hz;
    last_ok    = acc && legal && b[0];
    last_rd    = ins[25:21];
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_bundle", {12'd0, dut_bundle()}, 64'd0);
    chk("rst_cnt", {56'd0, illegal_cnt}, 64'd0);
    q.delete(); mcnt = 0; last_ok = 1'b0; stall_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                     input logic [4:0] s, input logic [4:0] t);
    return {op, d, s, t, 11'd0};
  endfunction

  int unsigned waits;
  int unsigned exp_wait;

  initial begin
    do_reset();

    // ADD rd1, rs2, rt3
    step(1'b1, 32'h0C22_1800, 1'b1, 1'b0);
    #1;
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_aluop", {61'd0, aluop}, 64'd3);
    chk("add_rd", {59'd0, rd}, 64'd1);
    chk("add_rs", {59'd0, rs}, 64'd2);
    chk("add_rt", {59'd0, rt}, 64'd3);
    chk("add_regwrite", {63'd0, regwrite}, 64'd1);

    // ADDI with all-ones immediate, then held under backpressure
    step(1'b1, 32'h2000_FFFF, 1'b1, 1'b0);
    #1;
    chk("addi_imm", {32'd0, imm}, 64'hFFFF_FFFF);
    chk("addi_use_imm", {63'd0, use_imm}, 64'd1);
    chk("addi_aluop", {61'd0, aluop}, 64'd3);
    for (int i = 0; i < 3; i++) step(1'b1, mk(6'd6, 5'd9, 5'd10, 5'd11), 1'b0, 1'b0);
    step(1'b1, mk(6'd6, 5'd9, 5'd10, 5'd11), 1'b1, 1'b0);
    step(1'b1, mk(6'd2, 5'd12, 5'd13, 5'd14), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Illegal opcode flood saturates the counter without producing bundles
    for (int i = 0; i < 300; i++) step(1'b1, {6'h20, 26'h155_5555}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("illegal_sat", {56'd0, illegal_cnt}, 64'd255);
    do_reset();

    // RAW dependency: hazard cycle plus one STALL cycle when the stall is built
`ifdef ACS_HAZARD_STALL_EN
    exp_wait = 2;
`else
    exp_wait = 0;
`endif
    step(1'b1, mk(6'd3, 5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(6'd6, 5'd7, 5'd5, 5'd0), 1'b1, 1'b0);
      if (dut_rdy_seen) break;
      waits++;
    end
    chk("hazard_wait", 64'(waits), 64'(exp_wait));
    step(1'b0, '0, 1'b1, 1'b0);

    // Producer writing r0 never causes a stall
    step(1'b1, mk(6'd3, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0);
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(6'd6, 5'd7, 5'd0, 5'd0), 1'b1, 1'b0);
      if (dut_rdy_seen) break;
      waits++;
    end
    chk("r0_wait", 64'(waits), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a held bundle (and STALL when built); counter must survive
    step(1'b1, {6'h21, 26'd0}, 1'b1, 1'b0);
    step(1'b1, mk(6'd3, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    step(1'b1, mk(6'd6, 5'd7, 5'd5, 5'd0), 1'b0, 1'b0);
    step(1'b1, mk(6'd6, 5'd7, 5'd5, 5'd0), 1'b0, 1'b1);
    #1;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cnt", {56'd0, illegal_cnt}, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset while a bundle is held and a dependent instruction waits
    step(1'b1, mk(6'd3, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    step(1'b1, mk(6'd6, 5'd7, 5'd5, 5'd0), 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic over a small register range so dependencies are frequent
    for (int i = 0; i < 800; i++) begin
      logic [5:0]  op;
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r < 10) op = 6'(r);
      else if (r == 10) op = 6'h3F;
      else op = 6'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0,
           {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)},
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
